// File: rtl/voltmeter_pkg.sv
// ---------------------------------------------------------------------------
// voltmeter_pkg
// Shared definitions for the dual-slope voltmeter: the sequencer state
// encoding, the counter width and the default phase lengths. The
// measurement counter and the benches import the same constants.
// ---------------------------------------------------------------------------
package voltmeter_pkg;

   localparam int COUNT_W = 12;

   localparam int AZ_CYCLES_DEFAULT        = 16;
   localparam int INT_CYCLES_DEFAULT       = 2048;
   localparam int MAX_DEINT_CYCLES_DEFAULT = 4095;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_AUTOZERO    = 3'd1,
      ST_INTEGRATE   = 3'd2,
      ST_DEINTEGRATE = 3'd3,
      ST_DONE        = 3'd4
   } seqState_e;

   // The phase timer starts at 0 on entry, so a phase that lasts
   // 'cycles' clock cycles ends when the timer reads cycles-1.
   function automatic logic [COUNT_W-1:0] lastTick(input int cycles);
      return COUNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/comparator_sync.sv
// ---------------------------------------------------------------------------
// comparator_sync
// Two-flop synchronizer that brings the asynchronous integrator
// comparator into the clk_i domain.
//   clk_i    in  : clock
//   rst_n_i  in  : asynchronous active-low reset, both flops clear to 0
//   async_i  in  : raw comparator level
//   sync_o   out : synchronized comparator level (2-cycle latency)
// ---------------------------------------------------------------------------
module comparator_sync (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   // The first flop may go metastable; only the second flop is used.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/dual_slope_sequencer.sv
// ---------------------------------------------------------------------------
// dual_slope_sequencer
// Conversion sequencer for the dual-slope ADC. Walks the analog switches
// through auto-zero, fixed-time integrate and deintegrate, drives the
// measurement counter's clear/enable, stops on the comparator trip and
// latches the returned count as the result.
//   clk_i / rst_n_i        : clock, asynchronous active-low reset
//   start_i                : conversion request, only honoured in IDLE
//   comparator_i           : asynchronous integrator zero-crossing flag
//   measurement_count_i    : count returned by the measurement counter
//   measurement_en_o       : counter increment, high through DEINTEGRATE
//   measurement_clear_o    : counter clear, first AUTOZERO cycle only
//   discharge_o            : integrator discharge switch
//   integrate_sel_o        : Vin to integrator
//   deintegrate_sel_o      : Vref to integrator
//   busy_o                 : conversion in progress
//   result_o               : last conversion count
//   result_valid_o         : result_o holds a completed conversion
//   overrange_o            : last conversion hit the deintegrate timeout
// ---------------------------------------------------------------------------
module dual_slope_sequencer
   import voltmeter_pkg::*;
#(
   parameter int AZ_CYCLES        = AZ_CYCLES_DEFAULT,
   parameter int INT_CYCLES       = INT_CYCLES_DEFAULT,
   parameter int MAX_DEINT_CYCLES = MAX_DEINT_CYCLES_DEFAULT
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic               comparator_i,
   input  logic [COUNT_W-1:0] measurement_count_i,
   output logic               measurement_en_o,
   output logic               measurement_clear_o,
   output logic               discharge_o,
   output logic               integrate_sel_o,
   output logic               deintegrate_sel_o,
   output logic               busy_o,
   output logic [COUNT_W-1:0] result_o,
   output logic               result_valid_o,
   output logic               overrange_o
);

   seqState_e          state_q, state_d;
   logic [COUNT_W-1:0] timer_q, timer_d;
   logic               compSync;
   logic               timeoutHit;

   logic               measEn_q, measEn_d;
   logic               measClear_q, measClear_d;
   logic               discharge_q, discharge_d;
   logic               integrateSel_q, integrateSel_d;
   logic               deintegrateSel_q, deintegrateSel_d;
   logic               busy_q, busy_d;
   logic [COUNT_W-1:0] result_q, result_d;
   logic               resultValid_q, resultValid_d;
   logic               overrange_q, overrange_d;

   comparator_sync uCompSync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .async_i (comparator_i),
      .sync_o  (compSync)
   );

   // Next-state, timer and next-output logic. The switch and counter
   // controls are decoded from the *next* state and then registered, so
   // each one is a clean flop output that is high for exactly the cycles
   // of its state. The timer restarts at 0 whenever the state changes.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q + 12'd1;
      timeoutHit = 1'b0;

      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (start_i) begin
               state_d = ST_AUTOZERO;
            end
         end
         ST_AUTOZERO: begin
            if (timer_q == lastTick(AZ_CYCLES)) begin
               state_d = ST_INTEGRATE;
            end
         end
         ST_INTEGRATE: begin
            if (timer_q == lastTick(INT_CYCLES)) begin
               state_d = ST_DEINTEGRATE;
            end
         end
         ST_DEINTEGRATE: begin
            // A comparator trip in the final allowed cycle still counts as
            // a good conversion, so it is checked before the timeout.
            if (compSync) begin
               state_d = ST_DONE;
            end else if (timer_q == lastTick(MAX_DEINT_CYCLES)) begin
               state_d    = ST_DONE;
               timeoutHit = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         timer_d = '0;
      end

      discharge_d      = (state_d == ST_IDLE) || (state_d == ST_AUTOZERO) ||
                         (state_d == ST_DONE);
      integrateSel_d   = (state_d == ST_INTEGRATE);
      deintegrateSel_d = (state_d == ST_DEINTEGRATE);
      measEn_d         = (state_d == ST_DEINTEGRATE);
      measClear_d      = (state_q == ST_IDLE) && (state_d == ST_AUTOZERO);
      busy_d           = (state_d != ST_IDLE);

      result_d      = result_q;
      resultValid_d = resultValid_q;
      overrange_d   = overrange_q;

      if ((state_q == ST_IDLE) && start_i) begin
         resultValid_d = 1'b0;
         overrange_d   = 1'b0;
      end
      if (timeoutHit) begin
         overrange_d = 1'b1;
      end
      // The counter has absorbed the last enable by the DONE cycle.
      if (state_q == ST_DONE) begin
         result_d      = measurement_count_i;
         resultValid_d = 1'b1;
      end
   end

   // State, timer and all registered outputs; discharge is the only
   // control that rests high so the integrator stays shorted in reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q          <= ST_IDLE;
         timer_q          <= '0;
         measEn_q         <= 1'b0;
         measClear_q      <= 1'b0;
         discharge_q      <= 1'b1;
         integrateSel_q   <= 1'b0;
         deintegrateSel_q <= 1'b0;
         busy_q           <= 1'b0;
         result_q         <= '0;
         resultValid_q    <= 1'b0;
         overrange_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         timer_q          <= timer_d;
         measEn_q         <= measEn_d;
         measClear_q      <= measClear_d;
         discharge_q      <= discharge_d;
         integrateSel_q   <= integrateSel_d;
         deintegrateSel_q <= deintegrateSel_d;
         busy_q           <= busy_d;
         result_q         <= result_d;
         resultValid_q    <= resultValid_d;
         overrange_q      <= overrange_d;
      end
   end

   assign measurement_en_o    = measEn_q;
   assign measurement_clear_o = measClear_q;
   assign discharge_o         = discharge_q;
   assign integrate_sel_o     = integrateSel_q;
   assign deintegrate_sel_o   = deintegrateSel_q;
   assign busy_o              = busy_q;
   assign result_o            = result_q;
   assign result_valid_o      = resultValid_q;
   assign overrange_o         = overrange_q;

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dual_slope_sequencer
// Self-checking bench for dual_slope_sequencer with short phase lengths and
// a small measurement counter model attached to the clear/enable outputs.
// ---------------------------------------------------------------------------
module tb_dual_slope_sequencer;
   import voltmeter_pkg::*;

   localparam int AZ    = 4;
   localparam int INTG  = 16;
   localparam int MAXD  = 64;
   localparam int ENTRY = AZ + INTG;

   logic               clk_i = 1'b0;
   logic               rst_n_i = 1'b0;
   logic               start_i = 1'b0;
   logic               comparator_i = 1'b0;
   logic [COUNT_W-1:0] measurement_count_i = 12'hABC;
   logic               measurement_en_o;
   logic               measurement_clear_o;
   logic               discharge_o;
   logic               integrate_sel_o;
   logic               deintegrate_sel_o;
   logic               busy_o;
   logic [COUNT_W-1:0] result_o;
   logic               result_valid_o;
   logic               overrange_o;

   int testsRun    = 0;
   int testsFailed = 0;

   dual_slope_sequencer #(
      .AZ_CYCLES        (AZ),
      .INT_CYCLES       (INTG),
      .MAX_DEINT_CYCLES (MAXD)
   ) dut (
      .clk_i               (clk_i),
      .rst_n_i             (rst_n_i),
      .start_i             (start_i),
      .comparator_i        (comparator_i),
      .measurement_count_i (measurement_count_i),
      .measurement_en_o    (measurement_en_o),
      .measurement_clear_o (measurement_clear_o),
      .discharge_o         (discharge_o),
      .integrate_sel_o     (integrate_sel_o),
      .deintegrate_sel_o   (deintegrate_sel_o),
      .busy_o              (busy_o),
      .result_o            (result_o),
      .result_valid_o      (result_valid_o),
      .overrange_o         (overrange_o)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk_i = ~clk_i;

   // Measurement counter stand-in. It has no reset and powers up non-zero,
   // so a correct result depends on the sequencer's clear pulse.
   always @(posedge clk_i) begin
      if (measurement_clear_o) begin
         measurement_count_i <= '0;
      end else if (measurement_en_o) begin
         measurement_count_i <= measurement_count_i + 12'd1;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_discharge"}, 32'(discharge_o), 32'd1);
      checkOutput({tag, "_controls"},
                  32'({measurement_en_o, measurement_clear_o, integrate_sel_o,
                       deintegrate_sel_o, busy_o}), 32'd0);
      checkOutput({tag, "_status"}, 32'({result_valid_o, overrange_o}), 32'd0);
      checkOutput({tag, "_result"}, 32'(result_o), 32'd0);
   endtask

   // Reference model. The comparator is raised just ahead of edge
   // compCycle+1 counted from the start edge; DEINTEGRATE is entered at
   // edge ENTRY. A rise ahead of entry-relative edge j ends the phase two
   // edges later, giving N = j+2, at least 1. Past MAXD the timeout wins.
   function automatic void modelConversion(input int compCycle, output int n,
                                           output int over);
      int j;
      if (compCycle < 0) begin
         n    = MAXD;
         over = 1;
         return;
      end
      j = compCycle + 1 - ENTRY;
      n = (j + 2 < 1) ? 1 : j + 2;
      if (n > MAXD) begin
         n    = MAXD;
         over = 1;
      end else begin
         over = 0;
      end
   endfunction

   // One full conversion from a single-cycle start pulse; compCycle < 0
   // keeps the comparator low. Every control is tallied per cycle and
   // compared with the timing the model predicts.
   task automatic applyStimulus(input string tag, input int compCycle);
      int n, over;
      int clears = 0, clearCycle = 0, integs = 0, firstInteg = 0;
      int ens = 0, firstEn = 0, overlap = 0, dischargeLow = 0, busyFall = 0;
      modelConversion(compCycle, n, over);
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      checkOutput({tag, "_valid_cleared"}, 32'({result_valid_o, overrange_o}), 32'd0);
      for (int t = 1; t <= 120; t++) begin
         if (t == compCycle + 1) comparator_i = 1'b1;
         if (!busy_o) begin
            busyFall = t;
            break;
         end
         if (measurement_clear_o) begin
            clears++;
            clearCycle = t;
         end
         if (integrate_sel_o) begin
            integs++;
            if (firstInteg == 0) firstInteg = t;
         end
         if (measurement_en_o) begin
            ens++;
            if (firstEn == 0) firstEn = t;
         end
         if (integrate_sel_o && deintegrate_sel_o) overlap++;
         if (!discharge_o) dischargeLow++;
         @(posedge clk_i); #1;
      end
      comparator_i = 1'b0;
      checkOutput({tag, "_clear_pulses"}, 32'(clears), 32'd1);
      checkOutput({tag, "_clear_cycle"}, 32'(clearCycle), 32'd1);
      checkOutput({tag, "_integrate_len"}, 32'(integs), 32'(INTG));
      checkOutput({tag, "_integrate_start"}, 32'(firstInteg), 32'(AZ + 1));
      checkOutput({tag, "_enable_count"}, 32'(ens), 32'(n));
      checkOutput({tag, "_enable_start"}, 32'(firstEn), 32'(ENTRY + 1));
      checkOutput({tag, "_sel_overlap"}, 32'(overlap), 32'd0);
      checkOutput({tag, "_discharge_low"}, 32'(dischargeLow), 32'(INTG + n));
      checkOutput({tag, "_busy_fall"}, 32'(busyFall), 32'(ENTRY + n + 2));
      checkOutput({tag, "_result"}, 32'(result_o), 32'(n));
      checkOutput({tag, "_result_valid"}, 32'(result_valid_o), 32'd1);
      checkOutput({tag, "_overrange"}, 32'(overrange_o), 32'(over));
   endtask

   initial begin
      int busyErrors;
      int clears;

      // Power-on reset: values must hold with no clock edge involved.
      #12;
      checkResetValues("por");
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      checkResetValues("idle");

      // Directed corner cases.
      applyStimulus("comp_at_10", ENTRY + 9);
      applyStimulus("timeout", -1);
      applyStimulus("comp_in_last", ENTRY + 61);
      applyStimulus("comp_too_late", ENTRY + 62);
      applyStimulus("comp_early", 5);

      // Random comparator timing across the whole conversion.
      for (int i = 0; i < 6; i++) begin
         int c;
         c = int'($urandom_range(0, ENTRY + 70));
         applyStimulus($sformatf("rand%0d_c%0d", i, c), c);
      end

      // start held high with the comparator high: back-to-back conversions
      // of N=1 (22 busy cycles) separated by one idle cycle each.
      comparator_i = 1'b1;
      start_i      = 1'b1;
      busyErrors   = 0;
      clears       = 0;
      @(posedge clk_i); #1;
      for (int t = 1; t <= 46; t++) begin
         if (t == 46) start_i = 1'b0;
         if (busy_o !== ((t % 23) != 0)) busyErrors++;
         if (measurement_clear_o) clears++;
         if (t == 23) checkOutput("b2b_first_result", 32'(result_o), 32'd1);
         @(posedge clk_i); #1;
      end
      comparator_i = 1'b0;
      checkOutput("b2b_busy_pattern_errors", 32'(busyErrors), 32'd0);
      checkOutput("b2b_clear_pulses", 32'(clears), 32'd2);
      checkOutput("b2b_second_result", 32'(result_o), 32'd1);

      // Reset in the middle of INTEGRATE, then a clean conversion.
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (9) begin
         @(posedge clk_i); #1;
      end
      checkOutput("mid_int_pre_reset", 32'(integrate_sel_o), 32'd1);
      #1 rst_n_i = 1'b0;
      #1 checkResetValues("mid_int_reset");
      #3 rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      applyStimulus("after_reset", ENTRY + 9);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
